// File: rtl/neuron_ctrl.sv
// Local-port scheduler between a mesh switch and one neuron MAC/activation datapath.
// Gathers one operand per predecessor, replays them to the MAC, then fans the activation out to successors.
module neuron_ctrl #(
  parameter int unsigned NUM_PRED  = 4,
  parameter int unsigned NUM_SUCC  = 2,
  parameter logic [1:0]  MY_X      = 2'b01,
  parameter logic [1:0]  MY_Y      = 2'b00,
  parameter logic [15:0] SUCC_LIST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pkt_in,
  input  logic        pkt_in_valid,
  output logic        pkt_in_ready,
  output logic [7:0]  mac_data,
  output logic [1:0]  mac_waddr,
  output logic        mac_valid,
  output logic        mac_start,
  output logic        mac_last,
  input  logic [7:0]  act_in,
  input  logic        act_valid,
  output logic [15:0] pkt_out,
  output logic        pkt_out_valid,
  input  logic        pkt_out_ready,
  output logic        busy,
  output logic        err_drop
);

  // state    | meaning
  // COLLECT  | accept operand packets until every predecessor slot is filled
  // ISSUE    | replay slots 0..NUM_PRED-1 to the MAC, one per cycle
  // WAIT_ACT | wait (no timeout) for the activation pulse
  // SEND     | present one result packet per successor under backpressure
  typedef enum logic [1:0] {COLLECT, ISSUE, WAIT_ACT, SEND} state_t;

  localparam logic [3:0] FULL_MASK = 4'((1 << NUM_PRED) - 1);
  localparam logic [1:0] LAST_PRED = 2'(NUM_PRED - 1);
  localparam logic [1:0] LAST_SUCC = 2'(NUM_SUCC - 1);
  localparam logic [2:0] PRED_LIM  = 3'(NUM_PRED);

  state_t      state;
  logic [3:0]  bitmap;
  logic [7:0]  slot [4];
  logic [1:0]  issue_idx;
  logic [1:0]  send_idx;

  logic [7:0]  in_data;
  logic [1:0]  src_y;
  logic [3:0]  dst;
  logic        accept;
  logic        store_ok;
  logic [3:0]  bitmap_nxt;
  logic        gather_done;
  logic        unused_src_x;

  // Source x is carried in the packet but slots are indexed by source y only.
  assign unused_src_x = ^pkt_in[7:6];

  function automatic logic [3:0] succ_entry(input logic [1:0] k);
    return SUCC_LIST[{k, 2'b00} +: 4];
  endfunction

  always_comb begin
    in_data     = pkt_in[15:8];
    src_y       = pkt_in[5:4];
    dst         = pkt_in[3:0];
    accept      = pkt_in_valid && pkt_in_ready && (state == COLLECT);
    store_ok    = accept && (dst == {MY_X, MY_Y}) && ({1'b0, src_y} < PRED_LIM) && !bitmap[src_y];
    bitmap_nxt  = bitmap | (store_ok ? (4'b0001 << src_y) : 4'b0000);
    gather_done = ((bitmap_nxt & FULL_MASK) == FULL_MASK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= COLLECT;
      bitmap        <= 4'b0000;
      for (int i = 0; i < 4; i++) slot[i] <= 8'h00;
      issue_idx     <= 2'd0;
      send_idx      <= 2'd0;
      pkt_in_ready  <= 1'b1;
      mac_data      <= 8'h00;
      mac_waddr     <= 2'd0;
      mac_valid     <= 1'b0;
      mac_start     <= 1'b0;
      mac_last      <= 1'b0;
      pkt_out       <= 16'h0000;
      pkt_out_valid <= 1'b0;
      busy          <= 1'b0;
      err_drop      <= 1'b0;
    end else begin
      err_drop  <= 1'b0;
      mac_valid <= 1'b0;
      mac_start <= 1'b0;
      mac_last  <= 1'b0;
      mac_data  <= 8'h00;
      mac_waddr <= 2'd0;
      case (state)
        COLLECT: begin
          if (store_ok) slot[src_y] <= in_data;
          if (accept && !store_ok) err_drop <= 1'b1;
          bitmap <= bitmap_nxt;
          if (gather_done) begin
            state        <= ISSUE;
            pkt_in_ready <= 1'b0;
            busy         <= 1'b1;
            issue_idx    <= 2'd0;
          end
        end
        ISSUE: begin
          mac_valid <= 1'b1;
          mac_data  <= slot[issue_idx];
          mac_waddr <= issue_idx;
          mac_start <= (issue_idx == 2'd0);
          mac_last  <= (issue_idx == LAST_PRED);
          if (issue_idx == LAST_PRED) begin
            state     <= WAIT_ACT;
            issue_idx <= 2'd0;
          end else begin
            issue_idx <= issue_idx + 2'd1;
          end
        end
        WAIT_ACT: begin
          if (act_valid) begin
            state         <= SEND;
            send_idx      <= 2'd0;
            pkt_out       <= {act_in, MY_X, MY_Y, succ_entry(2'd0)};
            pkt_out_valid <= 1'b1;
          end
        end
        SEND: begin
          // pkt_out_valid is always high here, so ready alone is the handshake
          if (pkt_out_ready) begin
            if (send_idx == LAST_SUCC) begin
              state         <= COLLECT;
              send_idx      <= 2'd0;
              bitmap        <= 4'b0000;
              pkt_out       <= 16'h0000;
              pkt_out_valid <= 1'b0;
              pkt_in_ready  <= 1'b1;
              busy          <= 1'b0;
            end else begin
              send_idx <= send_idx + 2'd1;
              pkt_out  <= {pkt_out[15:4], succ_entry(send_idx + 2'd1)};
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_ctrl.sv
// Self-checking bench for neuron_ctrl: directed scenarios plus randomized gather/issue/send rounds
// checked against a slot/queue reference model.
module tb_neuron_ctrl;

  localparam int unsigned NUM_PRED  = 4;
  localparam int unsigned NUM_SUCC  = 2;
  localparam logic [1:0]  MY_X      = 2'b01;
  localparam logic [1:0]  MY_Y      = 2'b00;
  localparam logic [15:0] SUCC_LIST = 16'h0098;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pkt_in;
  logic        pkt_in_valid;
  logic        pkt_in_ready;
  logic [7:0]  mac_data;
  logic [1:0]  mac_waddr;
  logic        mac_valid;
  logic        mac_start;
  logic        mac_last;
  logic [7:0]  act_in;
  logic        act_valid;
  logic [15:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic        busy;
  logic        err_drop;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_slot [4];
  bit         m_full [4];

  neuron_ctrl #(
    .NUM_PRED(NUM_PRED), .NUM_SUCC(NUM_SUCC), .MY_X(MY_X), .MY_Y(MY_Y), .SUCC_LIST(SUCC_LIST)
  ) dut (
    .clk(clk), .rst(rst),
    .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
    .mac_data(mac_data), .mac_waddr(mac_waddr), .mac_valid(mac_valid),
    .mac_start(mac_start), .mac_last(mac_last),
    .act_in(act_in), .act_valid(act_valid),
    .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
    .busy(busy), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit all_full();
    bit f = 1'b1;
    for (int i = 0; i < NUM_PRED; i++) f &= m_full[i];
    return f;
  endfunction

  function automatic logic [15:0] exp_pkt(input logic [7:0] a, input int j);
    logic [15:0] s = SUCC_LIST;
    return {a, MY_X, MY_Y, s[4*j +: 4]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send_pkt(input logic [7:0] d, input logic [1:0] sy, input logic [3:0] dst);
    bit exp_drop;
    chk("in_ready_before", pkt_in_ready, 1);
    pkt_in       = {d, 2'($urandom_range(0, 3)), sy, dst};
    pkt_in_valid = 1'b1;
    exp_drop = (dst != {MY_X, MY_Y}) || (sy >= NUM_PRED) || m_full[sy];
    if (!exp_drop) begin
      m_slot[sy] = d;
      m_full[sy] = 1'b1;
    end
    @(negedge clk);
    pkt_in_valid = 1'b0;
    chk("err_drop", err_drop, exp_drop);
    chk("busy_after_pkt", busy, all_full());
    chk("ready_after_pkt", pkt_in_ready, !all_full());
  endtask

  task automatic run_issue();
    chk("issue_latency", mac_valid, 0);
    for (int k = 0; k < NUM_PRED; k++) begin
      @(negedge clk);
      chk("mac_valid", mac_valid, 1);
      chk("mac_data", mac_data, m_slot[k]);
      chk("mac_waddr", mac_waddr, k);
      chk("mac_start", mac_start, k == 0);
      chk("mac_last", mac_last, k == NUM_PRED - 1);
    end
    @(negedge clk);
    chk("mac_idle_after", mac_valid, 0);
    chk("busy_wait", busy, 1);
  endtask

  task automatic run_wait_send(input logic [7:0] a, input int n_wait, input int first_stall, input bit hold_in);
    logic [15:0] exp_q[$];
    int guard = 0;
    int stalls = first_stall;
    bit rdy;
    for (int w = 0; w < n_wait; w++) begin
      chk("wait_no_out", pkt_out_valid, 0);
      chk("wait_no_mac", mac_valid, 0);
      @(negedge clk);
    end
    act_in = a;
    act_valid = 1'b1;
    if (hold_in) begin
      pkt_in = 16'($urandom);
      pkt_in_valid = 1'b1;
    end
    @(negedge clk);
    act_valid = 1'b0;
    act_in = 8'($urandom);
    for (int j = 0; j < NUM_SUCC; j++) exp_q.push_back(exp_pkt(a, j));
    while (exp_q.size() > 0 && guard < 200) begin
      chk("out_valid", pkt_out_valid, 1);
      chk("pkt_out", pkt_out, exp_q[0]);
      chk("in_blocked", pkt_in_ready, 0);
      chk("no_drop_send", err_drop, 0);
      if (stalls > 0) begin
        rdy = 1'b0;
        stalls--;
      end else begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      pkt_out_ready = rdy;
      @(negedge clk);
      if (rdy) void'(exp_q.pop_front());
      guard++;
    end
    pkt_out_ready = 1'b0;
    pkt_in_valid  = 1'b0;
    if (guard >= 200) chk("send_timeout", 0, 1);
    chk("out_valid_done", pkt_out_valid, 0);
    chk("ready_after_send", pkt_in_ready, 1);
    chk("busy_after_send", busy, 0);
    chk("no_drop_end", err_drop, 0);
    model_clear();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord[4];
    int tmp, r, pick;
    logic [3:0] bad;
    rst = 1'b0; pkt_in = '0; pkt_in_valid = 1'b0; act_in = '0; act_valid = 1'b0; pkt_out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    chk("rst_in_ready", pkt_in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_start", mac_start, 0);
    chk("rst_mac_last", mac_last, 0);
    chk("rst_mac_data", mac_data, 0);
    chk("rst_mac_waddr", mac_waddr, 0);
    chk("rst_pkt_out", pkt_out, 0);
    chk("rst_pkt_out_valid", pkt_out_valid, 0);
    chk("rst_err_drop", err_drop, 0);

    // act pulse while collecting must be ignored
    act_in = 8'h5A; act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
    chk("ign_act_valid", pkt_out_valid, 0);
    chk("ign_act_busy", busy, 0);
    @(negedge clk);
    chk("ign_act_valid2", pkt_out_valid, 0);

    // misroute, then ordered gather
    send_pkt(8'h77, 2'd0, 4'b1111);
    send_pkt(8'h10, 2'd0, {MY_X, MY_Y});
    send_pkt(8'h20, 2'd1, {MY_X, MY_Y});
    send_pkt(8'h30, 2'd2, {MY_X, MY_Y});
    send_pkt(8'h40, 2'd3, {MY_X, MY_Y});
    run_issue();
    run_wait_send(8'hA5, 2, 3, 1'b1);

    // out-of-order gather with a duplicate
    send_pkt(8'h31, 2'd3, {MY_X, MY_Y});
    send_pkt(8'h11, 2'd1, {MY_X, MY_Y});
    send_pkt(8'hEE, 2'd1, {MY_X, MY_Y});
    send_pkt(8'h01, 2'd0, {MY_X, MY_Y});
    send_pkt(8'h21, 2'd2, {MY_X, MY_Y});
    run_issue();
    run_wait_send(8'h3C, 0, 0, 1'b0);

    // reset during ISSUE abandons the inference
    send_pkt(8'h81, 2'd0, {MY_X, MY_Y});
    send_pkt(8'h82, 2'd1, {MY_X, MY_Y});
    send_pkt(8'h83, 2'd2, {MY_X, MY_Y});
    send_pkt(8'h84, 2'd3, {MY_X, MY_Y});
    @(negedge clk);
    chk("pre_rst_mac", mac_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    chk("midrst_mac_valid", mac_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", pkt_in_ready, 1);
    chk("midrst_out_valid", pkt_out_valid, 0);
    for (int i = 0; i < NUM_PRED; i++) send_pkt(8'(8'h90 + i), 2'(i), {MY_X, MY_Y});
    run_issue();
    run_wait_send(8'h7F, 1, 1, 1'b0);

    // randomized rounds
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < 4; i++) ord[i] = i;
      for (int i = 3; i > 0; i--) begin
        pick = $urandom_range(0, i);
        tmp = ord[i]; ord[i] = ord[pick]; ord[pick] = tmp;
      end
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          bad = 4'($urandom_range(0, 15));
          if (bad == {MY_X, MY_Y}) bad = bad ^ 4'hF;
          send_pkt(8'($urandom), 2'($urandom_range(0, 3)), bad);
        end else if (r == 1 && i > 0) begin
          send_pkt(8'($urandom), 2'(ord[$urandom_range(0, i - 1)]), {MY_X, MY_Y});
        end
        send_pkt(8'($urandom), 2'(ord[i]), {MY_X, MY_Y});
      end
      run_issue();
      run_wait_send(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_ctrl.md
Name: neuron_ctrl

Overview:
- Local-port scheduler between a mesh switch and one neuron MAC/activation datapath.
- Collects one operand packet from each predecessor and replays the operands to the MAC in fixed weight order, with start/last framing.
- Waits for the activation result, then emits one result packet per successor under router backpressure.
- Replaces ad-hoc arrival counting in the PE with a deterministic gather → issue → wait → send sequence.

Parameters:
- NUM_PRED, 4, number of predecessor packets per inference (1..4); slot index = source y.
- NUM_SUCC, 2, number of successor destinations (1..4).
- MY_X, 2'b01, own switch x coordinate.
- MY_Y, 2'b00, own switch y coordinate.
- SUCC_LIST, 16'h0000, packed successor coordinates; entry k = SUCC_LIST[4k+3:4k] = {x[1:0], y[1:0]}. Entry 0 is sent first.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- pkt_in  in  16  switch packet: [15:8] data, [7:6] src x, [5:4] src y, [3:2] dst x, [1:0] dst y.
- pkt_in_valid  in  1  pkt_in valid.
- pkt_in_ready  out  1  controller can accept pkt_in.
- mac_data  out  8  signed operand to MAC.
- mac_waddr  out  2  weight-memory address for mac_data.
- mac_valid  out  1  operand valid this cycle.
- mac_start  out  1  first operand of an inference; MAC clears its accumulator.
- mac_last  out  1  last operand; MAC adds bias and launches activation.
- act_in  in  8  activation result from the sigmoid ROM.
- act_valid  in  1  act_in valid, one-cycle pulse.
- pkt_out  out  16  result packet {act[7:0], MY_X, MY_Y, dst x, dst y}.
- pkt_out_valid  out  1  pkt_out valid.
- pkt_out_ready  in  1  switch accepts pkt_out.
- busy  out  1  high in any state other than COLLECT.
- err_drop  out  1  one-cycle pulse when an input packet is discarded.

Behaviour:
- Reset values (rst=0 at a clk edge): state=COLLECT, slot bitmap=0, pkt_in_ready=1, all mac_* outputs=0, pkt_out=0, pkt_out_valid=0, busy=0, err_drop=0, issue and send indices=0.
- Reset has priority over everything. Reset mid-operation abandons the inference with no further outputs.
- FSM states: COLLECT, ISSUE, WAIT_ACT, SEND.
- COLLECT:
  - pkt_in_ready=1. An input is accepted on a cycle with pkt_in_valid & pkt_in_ready.
  - Accepted packet with dst={MY_X,MY_Y}, src y < NUM_PRED, and its slot empty: store data[15:8] in slot[src y] and set its bitmap bit.
  - Otherwise the packet is consumed and dropped (misroute, out-of-range slot, or duplicate): err_drop=1 next cycle, and slot contents are unchanged.
  - When the bitmap becomes all-ones for slots 0..NUM_PRED-1, including on the same edge that stores the final packet, the next state is ISSUE and pkt_in_ready=0.
- ISSUE:
  - One operand per cycle, slot 0 first: mac_valid=1, mac_data=slot[i], mac_waddr=i.
  - mac_start=1 only when i=0. mac_last=1 only when i=NUM_PRED-1; with NUM_PRED=1 both are high in the same cycle.
  - Takes exactly NUM_PRED cycles, then WAIT_ACT.
- WAIT_ACT:
  - mac_* outputs=0. Waits with no timeout.
  - On act_valid, latch act_in and go to SEND.
  - act_valid in any other state is ignored.
- SEND:
  - pkt_out={act, MY_X, MY_Y, SUCC_LIST entry j}, pkt_out_valid=1.
  - pkt_out must stay stable while pkt_out_ready=0.
  - On a handshake, j increments and the next packet is presented the following cycle.
  - After the handshake for j=NUM_SUCC-1: pkt_out_valid=0, bitmap cleared, j=0, and the next state is COLLECT.
  - Throughput is one packet per cycle when ready is held high.
- Output timing: all outputs are registered; the first mac_valid comes one cycle after the edge that completes the bitmap.
- pkt_in_ready is low in ISSUE, WAIT_ACT and SEND. Inputs arriving then stay back-pressured in the switch, never dropped.
- busy = (state != COLLECT).

Test Plan:
- Ordered gather: NUM_PRED=4, four valid packets with src y 0,1,2,3 and data 0x10,0x20,0x30,0x40 → 4 consecutive mac_valid cycles, mac_waddr 0..3, data 0x10..0x40, mac_start on the first cycle, mac_last on the fourth.
- Out-of-order gather plus duplicate: src y order 3,1,1,0,2 → err_drop pulses once on the second y=1; issue order is still waddr 0,1,2,3 with the originally stored y=1 data.
- Misroute: dst=2'b11,2'b11 with MY=01,00 → err_drop=1; bitmap unchanged; state stays COLLECT.
- Successor send under backpressure: SUCC_LIST=16'h0098, act_in=0xA5, pkt_out_ready low for 3 cycles → pkt_out=0xA5_4_8 held stable; after acceptance 0xA5_4_9 is presented; after its acceptance, pkt_in_ready=1 next cycle.
- Ignored act and blocked input: act_valid pulsed during COLLECT → no output; pkt_in_valid held during SEND → pkt_in_ready=0 and no err_drop.
- Reset mid-operation: rst=0 for one cycle during ISSUE → next cycle mac_valid=0, busy=0, pkt_in_ready=1; a fresh 4-packet gather then completes normally.
